fpu_dispatch_queue: RTL
=======================

// Module: fpu_dispatch_queue
// PURPOSE
//  Parametrised instruction queue between the CPU-side FPU interface and the FPU core.
//  The CPU posts decoded FPU instructions (opcode, stack index, operand) without blocking.
//  A dispatch FSM issues them one at a time to the core over a start/complete handshake.
//  Adds a sticky error, optional stall-on-error, flush, and a WAIT-style ready output.
// PARAMETERS
//  DEPTH           4   queue entries; power of two, >= 2
//  DATA_W          80  operand width in bits (80 = extended real)
//  STALL_ON_ERROR  1   1: a core error blocks further issue until clear_error; 0: keep issuing
// PORTS
//  clk             in   1          system clock
//  reset_n         in   1          asynchronous reset, active low
//  enq_valid       in   1          CPU offers an instruction
//  enq_opcode      in   8          decoded internal opcode
//  enq_stack_idx   in   3          ST(i) index
//  enq_has_mem     in   1          instruction carries a memory operand
//  enq_operand     in   DATA_W     operand data
//  enq_ready       out  1          queue can accept an instruction this cycle
//  core_start      out  1          one-cycle issue strobe to the core
//  core_opcode     out  8          in-flight opcode, held stable until core_complete
//  core_stack_idx  out  3          in-flight stack index
//  core_has_mem    out  1          in-flight memory flag
//  core_operand    out  DATA_W     in-flight operand
//  core_complete   in   1          core finished the in-flight op (one-cycle pulse)
//  core_error      in   1          qualifies core_complete: the op raised an exception
//  flush           in   1          discard all queued, not yet issued entries
//  clear_error     in   1          clear the sticky error
//  count           out  $clog2(DEPTH)+1  queued entries, excluding the in-flight op
//  busy            out  1          count != 0 or an op is in flight
//  error           out  1          sticky error flag
//  ready           out  1          ~busy; the CPU's WAIT completes when ready = 1
// BEHAVIOUR
//  Reset (reset_n low, async)
//   - FIFO empty; count = 0; FSM = IDLE.
//   - core_* = 0; busy = 0; error = 0; ready = 1.
//   - enq_ready = 1, but no enqueue is accepted while reset_n is low.
//  Enqueue
//   - Accepted when enq_valid && enq_ready.
//   - enq_ready = (count != DEPTH) && !flush.
//   - Write pointer wraps modulo DEPTH.
//  Dispatch FSM
//   - IDLE: if count > 0 and !(error && STALL_ON_ERROR), move to ISSUE.
//   - ISSUE (one cycle):
//       - Pop the head into the in-flight registers; core_* outputs come from those registers.
//       - core_start = 1 for this cycle only; next state WAIT_DONE.
//   - WAIT_DONE: on core_complete, return to IDLE; if core_error, set error.
//   - Minimum latency: enqueue into an empty idle queue -> core_start 2 cycles later.
//   - Back-to-back ops: next core_start no earlier than 2 cycles after core_complete.
//  Boundary conditions
//   - Enqueue and pop in the same cycle: count unchanged; both take effect.
//   - Full queue: enq_ready = 0. A pop in the same cycle does not re-open it until the next cycle.
//   - flush: empties the FIFO (count = 0 next cycle). It does not abort the in-flight op;
//     that op's completion and error are still honoured.
//   - flush together with enq_valid: the entry is dropped (enq_ready = 0).
//   - core_complete outside WAIT_DONE: ignored.
//   - clear_error and an error-completion in the same cycle: set wins, error = 1.
//   - STALL_ON_ERROR = 0: error is only a status bit and issue continues.
//   - Reset mid-operation: everything drops at once, including the in-flight op; nothing is replayed.
//  Derived outputs
//   - busy = (count != 0) || (state != IDLE).
//   - ready = !busy.
//   - Both are combinational from registered state.
// TESTING
//  1. Single op: enqueue op 8'h10, idx 3, operand 80'h3FFF8000000000000000 into the empty queue
//     -> core_start at +2 cycles with those values. Hold core_complete low 5 cycles
//     -> busy = 1, ready = 0. Pulse core_complete -> busy = 0 and ready = 1 next cycle.
//  2. Fill: enqueue 4 ops with the core stalled -> the first issues, count = 3. Enqueue 2 more
//     -> count = 4 and enq_ready = 0 (the 6th is refused). Complete all ops
//     -> issue order matches enqueue order; count returns to 0.
//  3. Wrap: 3 rounds of 3 enqueue/complete pairs (DEPTH = 4)
//     -> pointers wrap; the 9 opcodes issue in order with no loss or duplication.
//  4. Error stall (STALL_ON_ERROR = 1): 2 ops queued, the first completes with core_error = 1
//     -> error = 1 and no core_start. Pulse clear_error -> the second op issues 2 cycles later.
//     Repeat with STALL_ON_ERROR = 0 -> the second op issues without clear_error.
//  5. Flush: 1 op in flight, 3 queued, assert flush together with enq_valid -> count = 0
//     and the new entry is dropped. The in-flight op still completes -> busy = 0.
//  6. Async reset mid-op: drop reset_n during WAIT_DONE with count = 2
//     -> core_* = 0, count = 0 and ready = 1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fpu_dispatch_queue.sv
// Posted-instruction queue between the CPU-side FPU interface and the FPU core.
// A small dispatch FSM issues queued ops one at a time over a start/complete handshake.
module fpu_dispatch_queue #(
    parameter int DEPTH          = 4,
    parameter int DATA_W         = 80,
    parameter bit STALL_ON_ERROR = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       enq_valid,
    input  logic [7:0]                 enq_opcode,
    input  logic [2:0]                 enq_stack_idx,
    input  logic                       enq_has_mem,
    input  logic [DATA_W-1:0]          enq_operand,
    output logic                       enq_ready,
    output logic                       core_start,
    output logic [7:0]                 core_opcode,
    output logic [2:0]                 core_stack_idx,
    output logic                       core_has_mem,
    output logic [DATA_W-1:0]          core_operand,
    input  logic                       core_complete,
    input  logic                       core_error,
    input  logic                       flush,
    input  logic                       clear_error,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       busy,
    output logic                       error,
    output logic                       ready,
    output logic [1:0]                 dbg_state
);
    // Handshake: an entry is taken on a clock edge where enq_valid && enq_ready.
    // The core sees core_start for one cycle; core_* stay stable until core_complete.
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [7:0]        opcode;
        logic [2:0]        stack_idx;
        logic              has_mem;
        logic [DATA_W-1:0] operand;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    entry_t           inflight_q;
    logic             start_q;
    logic             error_q;
    state_t           state;
    state_t           state_nxt;
    logic             push;
    logic             pop;
    logic             err_set;

    assign enq_ready = (count_q != CNT_W'(DEPTH)) && !flush;
    assign push      = enq_valid && enq_ready;

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        err_set   = 1'b0;
        case (state)
            IDLE: begin
                if ((count_q != '0) && !(error_q && STALL_ON_ERROR))
                    state_nxt = ISSUE;
            end
            ISSUE: begin
                // A flush landing here leaves nothing to issue; fall back to IDLE.
                state_nxt = IDLE;
                if ((count_q != '0) && !flush) begin
                    pop       = 1'b1;
                    state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (core_complete) begin
                    state_nxt = IDLE;
                    err_set   = core_error;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{opcode: enq_opcode, stack_idx: enq_stack_idx,
                             has_mem: enq_has_mem, operand: enq_operand};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (flush)
                rd_ptr <= wr_ptr;
            else if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (flush)
                count_q <= '0;
            else if (push && !pop)
                count_q <= count_q + CNT_W'(1);
            else if (pop && !push)
                count_q <= count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inflight_q <= '0;
            start_q    <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            start_q <= pop;
            if (pop)
                inflight_q <= mem[rd_ptr];
            // A same-cycle error completion beats clear_error.
            if (err_set)
                error_q <= 1'b1;
            else if (clear_error)
                error_q <= 1'b0;
        end
    end

    assign core_start     = start_q;
    assign core_opcode    = inflight_q.opcode;
    assign core_stack_idx = inflight_q.stack_idx;
    assign core_has_mem   = inflight_q.has_mem;
    assign core_operand   = inflight_q.operand;
    assign count          = count_q;
    assign busy           = (count_q != '0) || (state != IDLE);
    assign ready          = !busy;
    assign error          = error_q;
    assign dbg_state      = state;

endmodule
